// File: rtl/eon_mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
// Holds the func3 access-mode encodings, the stage FSM state type, the datapath
// width and the misalignment predicate used when MEM_STAGE_MISALIGN_TRAP_EN is defined.
package eon_mem_pkg;

    localparam int unsigned WIDTH = 32;

    // func3 access modes; loads and stores share encodings 0..2
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [0:0] {IDLE, WAIT} state_e;

    // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(logic [2:0] mode, logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (mode)
            LH, LHU: mis = addr_lo[0];
            LW:      mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// master: the stage (drives request, write enable, address, store data, byte enables).
// slave:  the memory (drives read data and the one-cycle acknowledge pulse).
interface mem_stage_if;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [3:0]  memByteEn;
    logic [31:0] memRData;
    logic        memAck;

    modport master (
        output memReq, memWe, memAddr, memWData, memByteEn,
        input  memRData, memAck
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData, memByteEn,
        output memRData, memAck
    );
endinterface

// File: rtl/mem_load_align.sv
// Combinational load alignment and extension.
// Ports: i_rdata (raw 32-bit memory word), i_addrLo (byte offset), i_mode (func3),
//        o_value (aligned, sign/zero-extended load value).
// Halfwords are selected by addr[1] only; words ignore the byte offset.
module mem_load_align
    import eon_mem_pkg::*;
#(
    parameter int unsigned width = WIDTH
) (
    input  logic [31:0]      i_rdata,
    input  logic [1:0]       i_addrLo,
    input  logic [2:0]       i_mode,
    output logic [width-1:0] o_value
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = i_rdata >> {i_addrLo, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_value = i_rdata;
        case (i_mode)
            LB:      o_value = {{24{w_byte[7]}}, w_byte};
            LH:      o_value = {{16{w_half[15]}}, w_half};
            LBU:     o_value = {24'h0, w_byte};
            LHU:     o_value = {16'h0, w_half};
            default: o_value = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX and writeback.
// Ports: clk/reset (sync, active-high); i_* EX results (read/write/noMEM flags, value,
//        address, func3 mode, rd); mem (master side of the data-memory bus);
//        o_valueOut/o_rdOut/o_writeBackOut registered writeback; o_stallOut freezes upstream.
// Optional: MEM_STAGE_MISALIGN_TRAP_EN adds o_misalignedOut and suppresses misaligned accesses.
module mem_stage
    import eon_mem_pkg::*;
#(
    parameter int unsigned width   = WIDTH,
    parameter int unsigned rsWidth = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_readIn,
    input  logic               i_writeIn,
    input  logic               i_noMEMIn,
    input  logic [width-1:0]   i_valueIn,
    input  logic [width-1:0]   i_addressIn,
    input  logic [2:0]         i_addressModeIn,
    input  logic [rsWidth-1:0] i_rdIn,
    mem_stage_if.master        mem,
    output logic [width-1:0]   o_valueOut,
    output logic [rsWidth-1:0] o_rdOut,
    output logic               o_writeBackOut,
    output logic               o_stallOut
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic               o_misalignedOut
`endif
);

    state_e             r_state;
    state_e             w_state_next;
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [2:0]         r_mode;
    logic [rsWidth-1:0] r_rd;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [width-1:0]   r_value;
    logic [rsWidth-1:0] r_rdOut;
    logic               r_wb;

    logic               w_access;
    logic               w_mis;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [width-1:0]   w_load;

    assign w_access = i_readIn | i_writeIn;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_mis           = is_misaligned(i_addressModeIn, i_addressIn[1:0]);
    assign o_misalignedOut = r_mis;
`else
    assign w_mis = 1'b0;
`endif

    // Store lanes are computed from the EX inputs and latched at issue.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_valueIn;
        case (i_addressModeIn)
            SB: begin
                w_be    = 4'b0001 << i_addressIn[1:0];
                w_wdata = {4{i_valueIn[7:0]}};
            end
            SH: begin
                w_be    = i_addressIn[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_valueIn[15:0]}};
            end
            default: ;
        endcase
    end

    mem_load_align #(
        .width (width)
    ) u_align (
        .i_rdata  (mem.memRData),
        .i_addrLo (r_addr[1:0]),
        .i_mode   (r_mode),
        .o_value  (w_load)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_access && !w_mis) w_state_next = WAIT;
            WAIT:    if (mem.memAck) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_mode  <= '0;
            r_rd    <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_value <= '0;
            r_rdOut <= '0;
            r_wb    <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            r_mis   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            r_mis   <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_wb <= 1'b0;
                        if (w_mis) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                            r_mis <= 1'b1;
`endif
                        end else begin
                            r_req   <= 1'b1;
                            // a load wins over a simultaneous store request
                            r_we    <= i_writeIn & ~i_readIn;
                            r_addr  <= i_addressIn;
                            r_mode  <= i_addressModeIn;
                            r_rd    <= i_rdIn;
                            r_wdata <= w_wdata;
                            r_be    <= w_be;
                        end
                    end else begin
                        r_value <= i_valueIn;
                        r_rdOut <= i_rdIn;
                        r_wb    <= i_noMEMIn && (i_rdIn != '0);
                    end
                end
                WAIT: begin
                    r_wb <= 1'b0;
                    if (mem.memAck) begin
                        r_req <= 1'b0;
                        r_we  <= 1'b0;
                        if (!r_we) begin
                            r_value <= w_load;
                            r_rdOut <= r_rd;
                            r_wb    <= (r_rd != '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.memReq    = r_req;
    assign mem.memWe     = r_we;
    assign mem.memAddr   = {r_addr[31:2], 2'b00};
    assign mem.memWData  = r_wdata;
    assign mem.memByteEn = r_be;

    assign o_valueOut     = r_value;
    assign o_rdOut        = r_rdOut;
    assign o_writeBackOut = r_wb;
    assign o_stallOut     = ((r_state == IDLE) && w_access) || ((r_state == WAIT) && !mem.memAck);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of EX transactions with expected bus and
// writeback results, a writeback scoreboard queue, and hand-written reset/misalign sequences.
module tb_mem_stage;
    import eon_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        readIn, writeIn, noMEMIn;
    logic [31:0] valueIn, addressIn;
    logic [2:0]  addressModeIn;
    logic [4:0]  rdIn;
    logic [31:0] valueOut;
    logic [4:0]  rdOut;
    logic        writeBackOut, stallOut;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalignedOut;
`endif

    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(
        .width   (32),
        .rsWidth (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_readIn        (readIn),
        .i_writeIn       (writeIn),
        .i_noMEMIn       (noMEMIn),
        .i_valueIn       (valueIn),
        .i_addressIn     (addressIn),
        .i_addressModeIn (addressModeIn),
        .i_rdIn          (rdIn),
        .mem             (bus),
        .o_valueOut      (valueOut),
        .o_rdOut         (rdOut),
        .o_writeBackOut  (writeBackOut),
        .o_stallOut      (stallOut)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .o_misalignedOut (misalignedOut)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic        nm;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] value;
        logic [4:0]  rdi;
        logic [31:0] rdata;
        int          delay;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_wb;
        logic        chk_val;
        logic [31:0] exp_val;
    } vec_t;

    typedef struct {
        logic        wb;
        logic        chk;
        logic [31:0] val;
        logic [4:0]  rd;
    } exp_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        readIn        = 1'b0;
        writeIn       = 1'b0;
        noMEMIn       = 1'b0;
        valueIn       = 32'h0;
        addressIn     = 32'h0;
        addressModeIn = 3'd0;
        rdIn          = 5'd0;
    endtask

    // Entered just after a negedge with the stage idle; returns just after a negedge.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        int   stalls;
        int   waits;
        logic acc;
        acc           = v.rd | v.wr;
        readIn        = v.rd;
        writeIn       = v.wr;
        noMEMIn       = v.nm;
        valueIn       = v.value;
        addressIn     = v.addr;
        addressModeIn = v.mode;
        rdIn          = v.rdi;
        e.wb  = v.exp_wb;
        e.chk = v.chk_val;
        e.val = v.exp_val;
        e.rd  = v.rdi;
        sbq.push_back(e);
        stalls = 0;
        waits  = 0;
        #1;
        if (stallOut) stalls++;
        @(negedge clk);
        if (acc) begin
            for (int c = 0; c <= v.delay; c++) begin
                bus.memAck   = (c == v.delay);
                bus.memRData = (c == v.delay) ? v.rdata : 32'h5A5A_A5A5;
                #1;
                if (stallOut) stalls++;
                if (bus.memReq && !bus.memAck) waits++;
                if (c == 0) begin
                    check($sformatf("v%0d_req", idx), {31'h0, bus.memReq}, 32'h1);
                    check($sformatf("v%0d_we", idx), {31'h0, bus.memWe}, {31'h0, v.exp_we});
                end
                if (c == v.delay) begin
                    check($sformatf("v%0d_addr", idx), bus.memAddr, v.addr & 32'hFFFF_FFFC);
                    check($sformatf("v%0d_wdata", idx), bus.memWData, v.exp_wdata);
                    check($sformatf("v%0d_be", idx), {28'h0, bus.memByteEn}, {28'h0, v.exp_be});
                    check($sformatf("v%0d_wb_bubble", idx), {31'h0, writeBackOut}, 32'h0);
                end
                @(negedge clk);
            end
            bus.memAck = 1'b0;
            check($sformatf("v%0d_waits", idx), waits, v.delay);
        end
        idle_inputs();
        check($sformatf("v%0d_stalls", idx), stalls, acc ? 1 + v.delay : 0);
        check($sformatf("v%0d_req_done", idx), {31'h0, bus.memReq}, 32'h0);
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL v%0d_sb: got empty queue expected entry", idx);
        end else begin
            e = sbq.pop_front();
            check($sformatf("v%0d_wb", idx), {31'h0, writeBackOut}, {31'h0, e.wb});
            if (e.chk) begin
                check($sformatf("v%0d_val", idx), valueOut, e.val);
                check($sformatf("v%0d_rd", idx), {27'h0, rdOut}, {27'h0, e.rd});
            end
        end
    endtask

    initial begin
        //         rd    wr    nm    mode addr          value          rdi    rdata          dly
        //         we    be        wdata          wb    chk   val
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h1234, 5'd5, 32'h0, 0,
                     1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 32'h1234};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 32'h55, 5'd0, 32'h0, 0,
                     1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h55};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, LB, 32'h103, 32'h0, 5'd7, 32'h80FF_FF00, 3,
                     1'b0, 4'b1000, 32'h0, 1'b1, 1'b1, 32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, LHU, 32'h202, 32'h0, 5'd9, 32'hBEEF_1234, 0,
                     1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h0000_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, SB, 32'h301, 32'hAB, 5'd3, 32'h0, 1,
                     1'b1, 4'b0010, 32'hABAB_ABAB, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, LW, 32'h400, 32'h0, 5'd31, 32'hDEAD_BEEF, 1,
                     1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, LH, 32'h502, 32'h0, 5'd10, 32'h8001_7FFF, 2,
                     1'b0, 4'b1100, 32'h0, 1'b1, 1'b1, 32'hFFFF_8001};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, LBU, 32'h601, 32'h0, 5'd12, 32'h1234_56F0, 0,
                     1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h0000_0056};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, SH, 32'h702, 32'hCAFE, 5'd4, 32'h0, 0,
                     1'b1, 4'b1100, 32'hCAFE_CAFE, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, SW, 32'h800, 32'h1234_5678, 5'd8, 32'h0, 2,
                     1'b1, 4'b1111, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, LW, 32'h900, 32'h0, 5'd1, 32'h0BAD_F00D, 0,
                     1'b0, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h0BAD_F00D};
        vecs[11] = '{1'b1, 1'b1, 1'b0, LB, 32'hA00, 32'h11, 5'd0, 32'h0000_007F, 1,
                     1'b0, 4'b0001, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_007F};

        idle_inputs();
        bus.memAck   = 1'b0;
        bus.memRData = 32'h0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, bus.memReq}, 32'h0);
        check("rst_we", {31'h0, bus.memWe}, 32'h0);
        check("rst_addr", bus.memAddr, 32'h0);
        check("rst_wdata", bus.memWData, 32'h0);
        check("rst_be", {28'h0, bus.memByteEn}, 32'h0);
        check("rst_val", valueOut, 32'h0);
        check("rst_rd", {27'h0, rdOut}, 32'h0);
        check("rst_wb", {31'h0, writeBackOut}, 32'h0);
        check("rst_stall", {31'h0, stallOut}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) apply(vecs[i], i);

        // Reset while waiting for ack; the ack arriving afterwards must be ignored.
        readIn        = 1'b1;
        addressIn     = 32'hB04;
        addressModeIn = LW;
        rdIn          = 5'd6;
        @(negedge clk);
        check("mid_req", {31'h0, bus.memReq}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", {31'h0, bus.memReq}, 32'h0);
        reset        = 1'b0;
        idle_inputs();
        bus.memAck   = 1'b1;
        bus.memRData = 32'hFFFF_FFFF;
        #1;
        check("mid_stall", {31'h0, stallOut}, 32'h0);
        @(negedge clk);
        bus.memAck = 1'b0;
        check("mid_req_after", {31'h0, bus.memReq}, 32'h0);
        check("mid_wb", {31'h0, writeBackOut}, 32'h0);
        check("mid_val", valueOut, 32'h0);
        check("mid_rd", {27'h0, rdOut}, 32'h0);
        check("mid_addr", bus.memAddr, 32'h0);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        readIn        = 1'b1;
        addressIn     = 32'h402;
        addressModeIn = LW;
        rdIn          = 5'd2;
        #1;
        check("mis_stall_present", {31'h0, stallOut}, 32'h1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mis_req", {31'h0, bus.memReq}, 32'h0);
        check("mis_pulse", {31'h0, misalignedOut}, 32'h1);
        check("mis_wb", {31'h0, writeBackOut}, 32'h0);
        check("mis_stall", {31'h0, stallOut}, 32'h0);
        @(negedge clk);
        check("mis_pulse_end", {31'h0, misalignedOut}, 32'h0);
        check("mis_req_end", {31'h0, bus.memReq}, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage sitting between EX and writeback.
- Consumes EX results: read/write/noMEM flags, value, address, func3 access mode, rd.
- Runs a req/ack handshake to a 32-bit data memory, generates byte enables and store-data lanes, and aligns and extends load data.
- Stalls upstream while a memory access is outstanding and presents registered writeback data.

Parameters:
- width, 32, datapath and address width (only 32 supported)
- rsWidth, 5, register index width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- readIn  input  1  EX requests a load
- writeIn  input  1  EX requests a store
- noMEMIn  input  1  EX result bypasses memory
- valueIn  input  width  ALU/link result, or store data for stores
- addressIn  input  width  effective byte address
- addressModeIn  input  3  func3 access mode
- rdIn  input  rsWidth  destination register
- memRData  input  32  memory read data
- memAck  input  1  memory completion, one-cycle pulse
- memReq  output  1  memory request, held until ack
- memWe  output  1  write enable for the current request
- memAddr  output  32  word-aligned address ({addr[31:2],2'b00})
- memWData  output  32  lane-replicated store data
- memByteEn  output  4  byte enables
- valueOut  output  width  writeback value
- rdOut  output  rsWidth  writeback register
- writeBackOut  output  1  register-write valid
- stallOut  output  1  freeze upstream stages

Behaviour:
- Reset: synchronous and active-high, on clk. All outputs are 0 and state is IDLE. Reset mid-access aborts: memReq drops on the next edge and a late memAck is ignored.
- Priority: readIn, then writeIn, then noMEMIn. A set read or write flag wins even if noMEMIn=1.
- States: IDLE, WAIT.
- IDLE with no access:
  - Register valueOut=valueIn and rdOut=rdIn.
  - writeBackOut=(noMEMIn && rdIn!=0).
  - Latency is 1 cycle.
- IDLE with readIn or writeIn:
  - Latch address, mode, rd and the store lanes.
  - memReq=1 and memWe=writeIn from the next edge; go to WAIT.
  - writeBackOut=0 (bubble).
- WAIT, memAck=0: hold memReq, memWe, memAddr, memWData and memByteEn stable; writeBackOut=0.
- WAIT, memAck=1, then on the next edge:
  - memReq=0; state returns to IDLE.
  - For a load: valueOut=aligned data, rdOut=latched rd, writeBackOut=(rd!=0).
  - For a store: writeBackOut=0.
- stallOut (combinational) = (IDLE && (readIn||writeIn)) || (WAIT && !memAck). Minimum load latency is 2 cycles (ack in the first WAIT cycle).
- Upstream holds its inputs while stallOut=1. Inputs are ignored in WAIT. memAck in IDLE is ignored.
- Store lanes by mode:
  - 0 SB: memByteEn=1<<addr[1:0]; data byte replicated x4.
  - 1 SH: memByteEn=addr[1]?4'b1100:4'b0011; data halfword replicated x2.
  - 2 SW, and any other mode: memByteEn=4'b1111.
- Load align: s = memRData>>(8*addr[1:0]).
  - 0 LB: sign-extend s[7:0].
  - 1 LH: sign-extend s[15:0] (halfword select by addr[1]).
  - 2 LW: full word.
  - 4 LBU: zero-extend byte.
  - 5 LHU: zero-extend halfword.
  - 3, 6, 7: full word.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0, handled per the optional feature.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access never asserts memReq.
  - Added output misalignedOut pulses 1 cycle; writeBackOut=0; no stall beyond the presenting cycle.
- Undefined:
  - Port absent; misaligned addresses are accessed anyway.
  - Halfword lanes use addr[1] only; word access ignores addr[1:0].

Decomposition:
- Package eon_mem_pkg: func3 access-mode localparams (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum {IDLE, WAIT}, width constant.
- Sub-module mem_load_align: combinational (rdata, addr[1:0], mode) -> width-bit extended value, reused by verification as a reference.

Test Plan:
- noMEMIn=1, valueIn=32'h1234, rdIn=5 -> next cycle valueOut=32'h1234, rdOut=5, writeBackOut=1, stallOut=0 throughout.
- LB addr=0x103, memRData=32'h80FF_FF00, ack after 3 WAIT cycles -> memAddr=0x100, memReq held 3 cycles, stallOut high 4 cycles, valueOut=32'hFFFFFF80, writeBackOut=1.
- LHU addr=0x202, memRData=32'hBEEF_1234, immediate ack -> valueOut=32'h0000BEEF 2 cycles after presentation.
- SB addr=0x301, valueIn=32'hAB -> memWe=1, memByteEn=4'b0010, memWData=32'hABABABAB; after ack writeBackOut=0.
- Reset asserted in WAIT, then memAck=1 one cycle later -> memReq=0, state IDLE, no writeback, all outputs 0.
- With the macro defined, LW addr=0x402 -> memReq never asserted, misalignedOut=1 for 1 cycle, writeBackOut=0.
